regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-port register file: the next generation of the team's 8×8 single-read register file. It provides `WIDTH`-bit × `DEPTH`-entry storage with one write port, two independent combinational read ports, and optional write-through bypass. A sequenced sweep-clear engine zeroes every entry one per cycle without a reset. It sits between the datapath operand-select logic and the ALU/result bus.

## Interface
- `WIDTH`, 8, data width in bits (≥1)
- `DEPTH`, 8, number of entries (power of two, ≥2); `AW = $clog2(DEPTH)`
- `BYPASS`, 1, 1 = read of the entry being written this cycle returns `wdata`
- `R0_ZERO`, 0, 1 = entry 0 reads as zero and ignores writes
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `we` in 1: write enable.
- `waddr` in AW: write address.
- `wdata` in WIDTH: write data.
- `raddr_a` in AW: read port A address.
- `rdata_a` out WIDTH: read port A data, combinational.
- `raddr_b` in AW: read port B address.
- `rdata_b` out WIDTH: read port B data, combinational.
- `sweep_req` in 1: start a sweep-clear; level sampled while idle.
- `sweep_busy` out 1: sweep in progress.
- `wr_drop` out 1: registered one-cycle pulse; a write was refused because of a sweep.

## Operation
- Reset (`clr`=0): all entries 0, FSM=IDLE, `sweep_busy`=0, `wr_drop`=0, sweep pointer 0. Both read outputs are therefore 0.
- Write: with `we`=1 and FSM=IDLE, `mem[waddr] <= wdata` at the clock edge. If `R0_ZERO`=1 and `waddr`=0, the write is silently ignored; `wr_drop` stays 0.
- Read: `rdata_x = mem[raddr_x]`. Ports A and B are fully independent and may use the same address.
- Bypass (`BYPASS`=1): if `we`=1, FSM=IDLE, and `raddr_x==waddr`, then `rdata_x=wdata`. This does not apply to entry 0 when `R0_ZERO`=1. With `BYPASS`=0 the read returns the old value until the edge.
- `R0_ZERO`=1: `rdata_x`=0 whenever `raddr_x`=0.
- FSM states: IDLE, SWEEP.
  - IDLE → SWEEP when `sweep_req`=1; pointer loads 0.
  - SWEEP: each cycle `mem[ptr]<=0` and `ptr++`. After writing entry `DEPTH-1`, go to IDLE; the pointer wraps to 0.
  - `sweep_req` is ignored during SWEEP. A held `sweep_req` restarts a new sweep on the cycle after returning to IDLE.
- During SWEEP:
  - `we` is refused. The next cycle `wr_drop`=1 for each refused cycle.
  - Bypass is disabled.
  - Reads return current storage, so already-swept entries read 0.
- Write and sweep-start in the same IDLE cycle: the write completes first, then the sweep clears that entry in turn.
- `clr` asserted mid-sweep: immediate return to the reset state; no partial state is retained.

## Timing
- Write latency: 1 cycle; data is visible on a non-bypassed read in the cycle after the edge.
- Bypass latency: 0 cycles.
- `sweep_busy` rises 1 cycle after `sweep_req` is sampled in IDLE. It stays high exactly `DEPTH` cycles, then falls.
- Entry k is zero from cycle k+2 after the request edge.
- `wr_drop` lags the refused `we` by 1 cycle.
- No combinational path from `sweep_req` or `we` to `sweep_busy`. The only combinational path from `we` is to `rdata_x`, via bypass.

## Structure
- Shared package `regfile_pkg`:
  - FSM state typedef `{IDLE, SWEEP}`.
  - Default `WIDTH`/`DEPTH` constants.
  - Helper function `addr_w(depth)`.
- Natural sub-module `regfile_rdport`: one read mux with bypass and R0 logic. It is instantiated twice (A, B).
- Storage is an array of `WIDTH`-bit registers with per-entry write enable from the write decoder. No RAM macro.

## Test plan
- Reset then read all addresses on A and B → all 0; `sweep_busy`=0; `wr_drop`=0.
- Write 8'hA5 to entry 3, 8'h3C to entry 7; next cycle A=3, B=7 → `rdata_a`=8'hA5, `rdata_b`=8'h3C.
- `BYPASS`=1: `we`=1, `waddr`=5, `wdata`=8'h77, `raddr_a`=5 in the same cycle → `rdata_a`=8'h77 that cycle. With `BYPASS`=0 → old value, then 8'h77 next cycle.
- `R0_ZERO`=1: write 8'hFF to entry 0 → `rdata_a(0)`=0, `wr_drop`=0.
- Fill all entries with 8'h11·k, pulse `sweep_req`:
  - `sweep_busy` is high for exactly 8 cycles.
  - `we` issued mid-sweep → `wr_drop` pulses the next cycle and the write is not stored.
  - Afterwards all entries read 0.
- Assert `clr` at sweep cycle 4 → `sweep_busy`=0 immediately and all entries 0. A new write after release stores normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the parametrised register file.
//   - sweep_state_e : sweep-clear sequencer states
//   - DEF_WIDTH / DEF_DEPTH : default geometry
//   - addr_w()      : address width for a given entry count
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Address width; never below one bit so a 2-entry file still has a port.
    function automatic int addr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_param_rdport.sv
// regfile_rdport: one combinational read port of the register file.
//   mem_flat_i : all entries, entry i at bits [i*WIDTH +: WIDTH]
//   raddr_i    : read address
//   byp_en_i   : a write is being accepted this cycle (bypass allowed)
//   waddr_i    : write address, wdata_i : write data
//   rdata_o    : read data
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0,
    parameter int AW      = addr_w(DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] mem_flat_i,
    input  logic [AW-1:0]          raddr_i,
    input  logic                   byp_en_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o
);

    // Read mux; the hard-zero entry has priority over bypass so entry 0
    // never forwards write data when it is tied to zero.
    always_comb begin
        rdata_o = '0;
        if ((R0_ZERO != 0) && (raddr_i == '0)) begin
            rdata_o = '0;
        end else if ((BYPASS != 0) && byp_en_i && (raddr_i == waddr_i)) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = mem_flat_i[raddr_i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: WIDTH x DEPTH register file, one write port, two
// combinational read ports, optional write-through bypass and a
// one-entry-per-cycle sweep-clear engine.
//   clk, clr (async active-low reset)
//   we, waddr, wdata         : write port
//   raddr_a/rdata_a, raddr_b/rdata_b : read ports
//   sweep_req  : start a sweep (sampled while idle)
//   sweep_busy : sweep in progress (registered)
//   wr_drop    : one-cycle pulse, a write was refused during a sweep
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0,
    localparam int AW     = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             sweep_req,
    output logic             sweep_busy,
    output logic             wr_drop
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    sweep_state_e     state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             wr_drop_q, wr_drop_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             sweep_s;
    logic             wr_ok_s;
    logic [DEPTH-1:0] ent_we_s;
    logic [WIDTH-1:0] ent_wd_s;
    logic [DEPTH*WIDTH-1:0] mem_flat_s;

    assign sweep_s = (state_q == ST_SWEEP);

    // Write acceptance and per-entry write decoder (sweep owns the port).
    always_comb begin
        wr_ok_s  = we && !sweep_s && !((R0_ZERO != 0) && (waddr == '0));
        ent_wd_s = sweep_s ? '0 : wdata;
        for (int i = 0; i < DEPTH; i++) begin
            if (sweep_s) begin
                ent_we_s[i] = (ptr_q == AW'(i));
            end else begin
                ent_we_s[i] = wr_ok_s && (waddr == AW'(i));
            end
        end
    end

    // Sweep sequencer next-state; the pointer wraps to 0 after the last entry.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sweep_req) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                wr_drop_d = we;
                ptr_d     = ptr_q + PTR_ONE;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_SWEEP);
    end

    // Sequencer state, pointer and registered status outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage array with per-entry write enables.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_we_s[i]) begin
                    mem_q[i] <= ent_wd_s;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat_s[g*WIDTH +: WIDTH] = mem_q[g];
    end

    regfile_rdport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .R0_ZERO(R0_ZERO), .AW(AW)
    ) u_rd_a (
        .mem_flat_i(mem_flat_s),
        .raddr_i   (raddr_a),
        .byp_en_i  (we && !sweep_s),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .rdata_o   (rdata_a)
    );

    regfile_rdport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .R0_ZERO(R0_ZERO), .AW(AW)
    ) u_rd_b (
        .mem_flat_i(mem_flat_s),
        .raddr_i   (raddr_b),
        .byp_en_i  (we && !sweep_s),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .rdata_o   (rdata_b)
    );

    assign sweep_busy = busy_q;
    assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a, raddr_b;
    logic       sweep_req;

    logic [7:0] rdata_a1, rdata_b1, rdata_a2, rdata_b2;
    logic       busy1, busy2, drop1, drop2;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: two storage images (one per parameter set) plus
    // the number of sweep cycles still to go.
    logic [7:0] m1 [DEPTH];
    logic [7:0] m2 [DEPTH];
    int         sweep_left;
    logic       exp_drop;

    always #5 clk = ~clk;

    // dut1: bypass on, entry 0 writable
    regfile_param #(.WIDTH(8), .DEPTH(DEPTH), .BYPASS(1), .R0_ZERO(0)) dut1 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1),
        .sweep_req(sweep_req), .sweep_busy(busy1), .wr_drop(drop1)
    );

    // dut2: no bypass, entry 0 hard zero
    regfile_param #(.WIDTH(8), .DEPTH(DEPTH), .BYPASS(0), .R0_ZERO(1)) dut2 (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a2), .raddr_b(raddr_b), .rdata_b(rdata_b2),
        .sweep_req(sweep_req), .sweep_busy(busy2), .wr_drop(drop2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m1[i] = 8'h00;
            m2[i] = 8'h00;
        end
        sweep_left = 0;
        exp_drop   = 1'b0;
    endtask

    function automatic logic [7:0] exp_rd(input int inst, input int ra);
        logic accept;
        accept = we && (sweep_left == 0);
        if (inst == 1) begin
            if (accept && (ra == int'(waddr))) return wdata;
            return m1[ra];
        end
        if (ra == 0) return 8'h00;
        return m2[ra];
    endfunction

    // What the clock edge does, stated directly from the block's rules.
    task automatic model_edge();
        if (sweep_left > 0) begin
            m1[DEPTH - sweep_left] = 8'h00;
            m2[DEPTH - sweep_left] = 8'h00;
            sweep_left--;
            exp_drop = we;
        end else begin
            exp_drop = 1'b0;
            if (we) begin
                m1[waddr] = wdata;
                if (waddr != 3'd0) m2[waddr] = wdata;
            end
            if (sweep_req) sweep_left = DEPTH;
        end
    endtask

    // One cycle: drive after the falling edge, check, then take the rising edge.
    task automatic step(input logic c, input logic w, input int wa, input logic [7:0] wd,
                        input int ra, input int rb, input logic rq);
        logic [2:0] a3;
        clr = c; we = w; wdata = wd; sweep_req = rq;
        a3 = 3'(wa); waddr = a3;
        a3 = 3'(ra); raddr_a = a3;
        a3 = 3'(rb); raddr_b = a3;
        if (!c) model_reset();
        #1;
        chk("rdata_a_byp", {24'd0, rdata_a1}, {24'd0, exp_rd(1, ra)});
        chk("rdata_b_byp", {24'd0, rdata_b1}, {24'd0, exp_rd(1, rb)});
        chk("rdata_a_r0",  {24'd0, rdata_a2}, {24'd0, exp_rd(2, ra)});
        chk("rdata_b_r0",  {24'd0, rdata_b2}, {24'd0, exp_rd(2, rb)});
        chk("sweep_busy1", {31'd0, busy1}, {31'd0, sweep_left > 0});
        chk("sweep_busy2", {31'd0, busy2}, {31'd0, sweep_left > 0});
        chk("wr_drop1",    {31'd0, drop1}, {31'd0, exp_drop});
        chk("wr_drop2",    {31'd0, drop2}, {31'd0, exp_drop});
        @(posedge clk);
        if (c) model_edge();
        @(negedge clk);
    endtask

    initial begin
        int busy_cycles;
        clr = 1'b0; we = 1'b0; waddr = 3'd0; wdata = 8'h00;
        raddr_a = 3'd0; raddr_b = 3'd0; sweep_req = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset: every address reads zero on both ports
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 0, 8'h00, i, DEPTH - 1 - i, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, 8'h00, i, i, 1'b0);

        // Basic writes and dual independent reads
        step(1'b1, 1'b1, 3, 8'hA5, 0, 0, 1'b0);
        step(1'b1, 1'b1, 7, 8'h3C, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 8'h00, 3, 7, 1'b0);
        chk("dir_a3", {24'd0, rdata_a1}, 32'h0000_00A5);
        chk("dir_b7", {24'd0, rdata_b1}, 32'h0000_003C);

        // Bypass: same-cycle forward on dut1, old value on dut2
        clr = 1'b1; we = 1'b1; waddr = 3'd5; wdata = 8'h77; raddr_a = 3'd5; raddr_b = 3'd5;
        sweep_req = 1'b0;
        #1;
        chk("byp_same_cycle", {24'd0, rdata_a1}, 32'h0000_0077);
        chk("nobyp_old",      {24'd0, rdata_a2}, 32'h0000_0000);
        step(1'b1, 1'b1, 5, 8'h77, 5, 5, 1'b0);
        step(1'b1, 1'b0, 0, 8'h00, 5, 5, 1'b0);
        chk("nobyp_next", {24'd0, rdata_a2}, 32'h0000_0077);

        // Entry 0 write: stored on dut1, ignored (no drop) on dut2
        step(1'b1, 1'b1, 0, 8'hFF, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b0);
        chk("r0_zero", {24'd0, rdata_a2}, 32'h0000_0000);
        chk("r0_drop", {31'd0, drop2}, 32'h0);

        // Fill 0x11*k, sweep, refused write mid-sweep
        for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b1, k, 8'(8'h11 * k), k, 0, 1'b0);
        busy_cycles = 0;
        step(1'b1, 1'b0, 0, 8'h00, 0, 1, 1'b0);
        step(1'b1, 1'b0, 0, 8'h00, 7, 6, 1'b1);
        if (busy1) busy_cycles++;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, (i == 3), 2, 8'h99, 2, i % DEPTH, 1'b0);
            if (busy1) busy_cycles++;
            if (i == 3) chk("wr_drop_pulse", {31'd0, drop1}, 32'h1);
        end
        chk("busy_len", busy_cycles, 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 0, 8'h00, i, i, 1'b0);
            chk("swept_zero", {24'd0, rdata_a1}, 32'h0);
        end

        // Reset mid-sweep, then normal write after release
        for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b1, k, 8'(8'h11 * k + 1), 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 8'h00, 6, 7, 1'b0);
        step(1'b0, 1'b0, 0, 8'h00, 6, 7, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 0, 8'h00, i, DEPTH - 1 - i, 1'b0);
        step(1'b1, 1'b1, 6, 8'h5A, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 8'h00, 6, 6, 1'b0);
        chk("post_clr_wr", {24'd0, rdata_a2}, 32'h0000_005A);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) != 0),
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, DEPTH - 1)),
                 8'($urandom),
                 int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, DEPTH - 1)),
                 $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
